l1a_match_fifo: RTL and testbench

//  Downstream of the trigger control stage. On each L1A to the CFEBs, collects the per-CFEB LCT/L1A match bits and the LCT error flag over a short window.

---
 rtl/l1a_match_fifo.sv | 202 ++++++++++++++++++++
 tb/tb_l1a_match_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/l1a_match_fifo.sv
// l1a_match_fifo
//   Collects per-CFEB LCT/L1A match bits and the LCT error flag over a short
//   window after each L1A to the CFEBs. Each event is tagged with a 24-bit L1A
//   number and queued in a first-word-fall-through FIFO. The readout controller
//   pops one entry per event.
//
//   Ports
//     CLK        in   40 MHz system clock, rising edge
//     RST        in   synchronous reset, active-high
//     L1A        in   L1A to CFEBs (level, may last more than one cycle)
//     L1A_MATCH  in   per-CFEB match bits [5:1]
//     LCTERR     in   ALCT/CFEB LCT mismatch flag
//     RD_EN      in   pop head entry (ignored when EMPTY)
//     DOUT       out  head entry, valid while !EMPTY
//     EMPTY      out  FIFO empty
//     FULL       out  FIFO full
//     COUNT      out  occupancy 0..2**ADDR_W
//     OVFL       out  sticky: at least one event dropped since reset
//     L1ACNT     out  number of the last L1A seen
//
//   Entry format: [31] DROP  [30] LCTERR  [29:25] match[5:1]
//                 [24] NOMATCH  [23:0] L1A number
module l1a_match_fifo #(
  parameter int ADDR_W    = 4,
  parameter int MATCH_WIN = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              L1A,
  input  logic [5:1]        L1A_MATCH,
  input  logic              LCTERR,
  input  logic              RD_EN,
  output logic [31:0]       DOUT,
  output logic              EMPTY,
  output logic              FULL,
  output logic [ADDR_W:0]   COUNT,
  output logic              OVFL,
  output logic [23:0]       L1ACNT
);

  localparam int             DEPTH    = 1 << ADDR_W;
  localparam logic [3:0]     WIN_LAST = 4'(MATCH_WIN - 1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_COLLECT
  } state_e;

  function automatic logic [30:0] build_entry(input logic       err,
                                              input logic [5:1] match,
                                              input logic [23:0] num);
    return {err, match, (match == 5'b00000), num};
  endfunction

  state_e       state_q, state_d;
  logic         l1a_q;
  logic         edge_w;
  logic [23:0]  l1acnt_q, l1acnt_d;
  logic [3:0]   win_q, win_d;
  logic [5:1]   acc_match_q, acc_match_d;
  logic         acc_err_q, acc_err_d;
  logic [23:0]  evt_num_q, evt_num_d;
  logic         push_q, push_d;
  logic [30:0]  entry_q, entry_d;

  logic [31:0]        mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic               full_q, empty_q;
  logic               ovfl_q, ovfl_d;
  logic               drop_pend_q, drop_pend_d;
  logic               do_wr, do_rd, do_drop;

  // Event collection: edge detect, L1A numbering and the IDLE/COLLECT FSM.
  // A closing event is latched into entry_q and pushed in the following cycle.
  always_comb begin
    edge_w      = L1A & ~l1a_q;
    l1acnt_d    = edge_w ? l1acnt_q + 24'd1 : l1acnt_q;
    state_d     = state_q;
    win_d       = win_q;
    acc_match_d = acc_match_q;
    acc_err_d   = acc_err_q;
    evt_num_d   = evt_num_q;
    push_d      = 1'b0;
    entry_d     = entry_q;

    case (state_q)
      S_IDLE: begin
        if (edge_w) begin
          evt_num_d   = l1acnt_d;
          acc_match_d = L1A_MATCH;
          acc_err_d   = LCTERR;
          win_d       = 4'd1;
          if (MATCH_WIN == 1) begin
            push_d  = 1'b1;
            entry_d = build_entry(LCTERR, L1A_MATCH, l1acnt_d);
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (edge_w) begin
          // Close the running event on last cycle's accumulation; this
          // cycle's inputs open the next event.
          push_d      = 1'b1;
          entry_d     = build_entry(acc_err_q, acc_match_q, evt_num_q);
          evt_num_d   = l1acnt_d;
          acc_match_d = L1A_MATCH;
          acc_err_d   = LCTERR;
          win_d       = 4'd1;
        end else begin
          acc_match_d = acc_match_q | L1A_MATCH;
          acc_err_d   = acc_err_q | LCTERR;
          win_d       = win_q + 4'd1;
          if (win_q == WIN_LAST) begin
            push_d  = 1'b1;
            entry_d = build_entry(acc_err_d, acc_match_d, evt_num_q);
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control. A push into a full FIFO survives only if a pop frees the
  // head slot in the same cycle; otherwise it is dropped and the next
  // written entry is flagged.
  always_comb begin
    do_rd       = RD_EN & ~empty_q;
    do_wr       = push_q & (~full_q | RD_EN);
    do_drop     = push_q & full_q & ~RD_EN;
    wr_ptr_d    = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q;
    ovfl_d      = ovfl_q | do_drop;
    drop_pend_d = drop_pend_q;
    if (do_drop) begin
      drop_pend_d = 1'b1;
    end else if (do_wr) begin
      drop_pend_d = 1'b0;
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      l1a_q       <= 1'b0;
      l1acnt_q    <= 24'd0;
      win_q       <= 4'd0;
      push_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      ovfl_q      <= 1'b0;
      drop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      l1a_q       <= L1A;
      l1acnt_q    <= l1acnt_d;
      win_q       <= win_d;
      push_q      <= push_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= (count_d == DEPTH_C);
      empty_q     <= (count_d == '0);
      ovfl_q      <= ovfl_d;
      drop_pend_q <= drop_pend_d;
    end
  end

  // Datapath registers carry no reset; their use is qualified by control.
  always_ff @(posedge CLK) begin
    acc_match_q <= acc_match_d;
    acc_err_q   <= acc_err_d;
    evt_num_q   <= evt_num_d;
    entry_q     <= entry_d;
    if (do_wr) begin
      mem[wr_ptr_q] <= {drop_pend_q, entry_q};
    end
  end

  // Memory is not cleared by reset, so the head is masked while empty.
  assign DOUT   = empty_q ? 32'd0 : mem[rd_ptr_q];
  assign EMPTY  = empty_q;
  assign FULL   = full_q;
  assign COUNT  = count_q;
  assign OVFL   = ovfl_q;
  assign L1ACNT = l1acnt_q;

endmodule

// File: tb/tb_l1a_match_fifo.sv
// Directed testbench for l1a_match_fifo (ADDR_W=4, MATCH_WIN=4).
module tb_l1a_match_fifo;

  logic        CLK;
  logic        RST;
  logic        L1A;
  logic [5:1]  L1A_MATCH;
  logic        LCTERR;
  logic        RD_EN;
  logic [31:0] DOUT;
  logic        EMPTY;
  logic        FULL;
  logic [4:0]  COUNT;
  logic        OVFL;
  logic [23:0] L1ACNT;

  int pass_cnt  = 0;
  int total_cnt = 0;

  l1a_match_fifo #(.ADDR_W(4), .MATCH_WIN(4)) dut (
    .CLK(CLK), .RST(RST), .L1A(L1A), .L1A_MATCH(L1A_MATCH), .LCTERR(LCTERR),
    .RD_EN(RD_EN), .DOUT(DOUT), .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT),
    .OVFL(OVFL), .L1ACNT(L1ACNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; L1A = 1'b0; L1A_MATCH = 5'b0; LCTERR = 1'b0; RD_EN = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic pulse_l1a();
    L1A = 1'b1;
    tick();
    L1A = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (EMPTY !== 1'b1) $display("FAIL reset_empty: got %b want 1", EMPTY); else pass_cnt++;
    total_cnt++; if (FULL !== 1'b0) $display("FAIL reset_full: got %b want 0", FULL); else pass_cnt++;
    total_cnt++; if (COUNT !== 5'd0) $display("FAIL reset_count: got %0d want 0", COUNT); else pass_cnt++;
    total_cnt++; if (OVFL !== 1'b0) $display("FAIL reset_ovfl: got %b want 0", OVFL); else pass_cnt++;
    total_cnt++; if (L1ACNT !== 24'd0) $display("FAIL reset_l1acnt: got %h want 0", L1ACNT); else pass_cnt++;
    total_cnt++; if (DOUT !== 32'd0) $display("FAIL reset_dout: got %h want 0", DOUT); else pass_cnt++;
    // L1A held high through reset is an edge in the first cycle after reset
    RST = 1'b1; L1A = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    tick();
    L1A = 1'b0;
    total_cnt++; if (L1ACNT !== 24'd1) $display("FAIL held_l1a_edge: got %h want 1", L1ACNT); else pass_cnt++;
  endtask

  task automatic test_single_event();
    do_reset();
    pulse_l1a();                 // edge in cycle t, now t+1
    tick();                      // t+2
    L1A_MATCH = 5'b00100;
    tick();                      // t+3
    L1A_MATCH = 5'b00000;
    tick();                      // t+4: push cycle
    total_cnt++; if (EMPTY !== 1'b1) $display("FAIL single_empty_t4: got %b want 1", EMPTY); else pass_cnt++;
    tick();                      // t+5
    total_cnt++; if (EMPTY !== 1'b0) $display("FAIL single_empty_t5: got %b want 0", EMPTY); else pass_cnt++;
    total_cnt++; if (DOUT !== 32'h0800_0001) $display("FAIL single_dout: got %h want 08000001", DOUT); else pass_cnt++;
    total_cnt++; if (COUNT !== 5'd1) $display("FAIL single_count: got %0d want 1", COUNT); else pass_cnt++;
  endtask

  task automatic test_early_close();
    do_reset();
    L1A = 1'b1;                  // t
    tick();
    L1A = 1'b0; L1A_MATCH = 5'b00001;   // t+1
    tick();
    L1A = 1'b1; L1A_MATCH = 5'b10000;   // t+2: second edge
    tick();
    L1A = 1'b0; L1A_MATCH = 5'b00000;
    repeat (8) tick();
    total_cnt++; if (COUNT !== 5'd2) $display("FAIL early_count: got %0d want 2", COUNT); else pass_cnt++;
    total_cnt++; if (DOUT !== 32'h0200_0001) $display("FAIL early_first: got %h want 02000001", DOUT); else pass_cnt++;
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
    total_cnt++; if (DOUT !== 32'h2000_0002) $display("FAIL early_second: got %h want 20000002", DOUT); else pass_cnt++;
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
    total_cnt++; if (EMPTY !== 1'b1) $display("FAIL early_drained: got %b want 1", EMPTY); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      pulse_l1a();
      repeat (9) tick();
    end
    total_cnt++; if (COUNT !== 5'd16) $display("FAIL ovf_count: got %0d want 16", COUNT); else pass_cnt++;
    total_cnt++; if (FULL !== 1'b1) $display("FAIL ovf_full: got %b want 1", FULL); else pass_cnt++;
    total_cnt++; if (OVFL !== 1'b1) $display("FAIL ovf_flag: got %b want 1", OVFL); else pass_cnt++;
    total_cnt++; if (L1ACNT !== 24'd18) $display("FAIL ovf_l1acnt: got %0d want 18", L1ACNT); else pass_cnt++;
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
    total_cnt++; if (COUNT !== 5'd15) $display("FAIL ovf_pop_count: got %0d want 15", COUNT); else pass_cnt++;
    pulse_l1a();
    repeat (9) tick();
    total_cnt++; if (COUNT !== 5'd16) $display("FAIL ovf_refill: got %0d want 16", COUNT); else pass_cnt++;
    for (int n = 2; n <= 17; n++) begin
      exp = (n == 17) ? 32'h8100_0013 : (32'h0100_0000 | 32'(n));
      total_cnt++; if (DOUT !== exp) $display("FAIL ovf_entry_%0d: got %h want %h", n, DOUT, exp); else pass_cnt++;
      RD_EN = 1'b1;
      tick();
      RD_EN = 1'b0;
    end
    total_cnt++; if (EMPTY !== 1'b1) $display("FAIL ovf_drained: got %b want 1", EMPTY); else pass_cnt++;
    total_cnt++; if (OVFL !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", OVFL); else pass_cnt++;
  endtask

  task automatic test_l1acnt_wrap();
    logic [31:0] exp [3];
    exp[0] = 32'h01FF_FFFF;
    exp[1] = 32'h0100_0000;
    exp[2] = 32'h0100_0001;
    do_reset();
    force dut.l1acnt_q = 24'hFFFFFE;
    tick();
    release dut.l1acnt_q;
    tick();
    for (int i = 0; i < 3; i++) begin
      pulse_l1a();
      repeat (9) tick();
    end
    total_cnt++; if (COUNT !== 5'd3) $display("FAIL wrap_count: got %0d want 3", COUNT); else pass_cnt++;
    total_cnt++; if (L1ACNT !== 24'd1) $display("FAIL wrap_l1acnt: got %h want 000001", L1ACNT); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (DOUT !== exp[i]) $display("FAIL wrap_entry_%0d: got %h want %h", i, DOUT, exp[i]); else pass_cnt++;
      RD_EN = 1'b1;
      tick();
      RD_EN = 1'b0;
    end
  endtask

  task automatic test_lcterr_nomatch();
    do_reset();
    pulse_l1a();
    LCTERR = 1'b1;
    tick();
    LCTERR = 1'b0;
    repeat (6) tick();
    total_cnt++; if (DOUT[30] !== 1'b1) $display("FAIL err_bit30: got %b want 1", DOUT[30]); else pass_cnt++;
    total_cnt++; if (DOUT[24] !== 1'b1) $display("FAIL err_nomatch: got %b want 1", DOUT[24]); else pass_cnt++;
    total_cnt++; if (DOUT[29:25] !== 5'b0) $display("FAIL err_match: got %b want 00000", DOUT[29:25]); else pass_cnt++;
    total_cnt++; if (DOUT !== 32'h4100_0001) $display("FAIL err_dout: got %h want 41000001", DOUT); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      pulse_l1a();
      repeat (9) tick();
    end
    total_cnt++; if (FULL !== 1'b1) $display("FAIL fpp_full_before: got %b want 1", FULL); else pass_cnt++;
    pulse_l1a();                 // now t+1
    repeat (3) tick();           // t+4: push cycle
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
    total_cnt++; if (COUNT !== 5'd16) $display("FAIL fpp_count: got %0d want 16", COUNT); else pass_cnt++;
    total_cnt++; if (OVFL !== 1'b0) $display("FAIL fpp_ovfl: got %b want 0", OVFL); else pass_cnt++;
    total_cnt++; if (FULL !== 1'b1) $display("FAIL fpp_full_after: got %b want 1", FULL); else pass_cnt++;
    for (int n = 2; n <= 17; n++) begin
      total_cnt++;
      if (DOUT !== (32'h0100_0000 | 32'(n)))
        $display("FAIL fpp_entry_%0d: got %h want %h", n, DOUT, 32'h0100_0000 | 32'(n));
      else pass_cnt++;
      RD_EN = 1'b1;
      tick();
      RD_EN = 1'b0;
    end
  endtask

  task automatic test_rst_mid_event();
    do_reset();
    pulse_l1a();
    pulse_l1a();
    tick();
    pulse_l1a();                 // second event now collecting, first queued
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    total_cnt++; if (EMPTY !== 1'b1) $display("FAIL rst_empty: got %b want 1", EMPTY); else pass_cnt++;
    total_cnt++; if (COUNT !== 5'd0) $display("FAIL rst_count: got %0d want 0", COUNT); else pass_cnt++;
    total_cnt++; if (L1ACNT !== 24'd0) $display("FAIL rst_l1acnt: got %h want 0", L1ACNT); else pass_cnt++;
    repeat (8) tick();
    total_cnt++; if (EMPTY !== 1'b1) $display("FAIL rst_abandoned: got %b want 1", EMPTY); else pass_cnt++;
  endtask

  initial begin
    RST = 1'b1; L1A = 1'b0; L1A_MATCH = 5'b0; LCTERR = 1'b0; RD_EN = 1'b0;
    test_reset();
    test_single_event();
    test_early_close();
    test_overflow();
    test_l1acnt_wrap();
    test_lcterr_nomatch();
    test_full_push_pop();
    test_rst_mid_event();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
